// File: rtl/spi_slave_regfile.sv
// SPI mode-3 responder over a 64x8 register bank; reg 0x00 is a read-only device ID.
// SPI inputs are synchronised into clk; edge pulses drive a single frame FSM.
module spi_slave_regfile #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SPI_CLK,
  input  logic       SPI_CS,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       miso_oe,
  output logic       busy,
  input  logic       loc_we,
  input  logic [5:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  // CS chain resets low so a reset released mid-frame parks in WAIT_CS
  // instead of seeing a spurious CS fall.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [6:0] shift_q;
  logic       rw_q, mb_q;
  logic [5:0] addr_q;
  logic [7:0] tx_q;
  logic       miso_q, oe_q;
  logic       wr_strobe_q;
  logic [5:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] mem_q [0:63];

  logic [7:0] byte_d;
  logic       byte_done_d;
  logic [5:0] addr_nxt_d;
  logic [5:0] fetch_addr_d;
  logic [7:0] fetch_d;
  logic       spi_we_d;

  assign byte_d       = {shift_q, mosi_s};
  assign byte_done_d  = sclk_rise && (cnt_q == 3'd7);
  assign addr_nxt_d   = mb_q ? addr_q + 6'd1 : addr_q;
  assign fetch_addr_d = (state_q == CMD) ? byte_d[5:0] : addr_nxt_d;
  assign fetch_d      = (fetch_addr_d == 6'd0) ? DEVID : mem_q[fetch_addr_d];
  assign spi_we_d     = (state_q == DATA) && byte_done_d && !rw_q &&
                        (addr_q != 6'd0) && !cs_rise;

  // SPI commit is the later assignment so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= (i == 0) ? DEVID : 8'h00;
    end else begin
      if (loc_we && (loc_addr != 6'd0)) mem_q[loc_addr] <= loc_wdata;
      if (spi_we_d) mem_q[addr_q] <= byte_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      rw_q        <= 1'b0;
      mb_q        <= 1'b0;
      addr_q      <= 6'd0;
      tx_q        <= 8'd0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'd0;
    end else begin
      wr_strobe_q <= spi_we_d;
      if (spi_we_d) begin
        wr_addr_q <= addr_q;
        wr_data_q <= byte_d;
      end
      if (cs_rise) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
        miso_q  <= 1'b0;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q <= CMD;
              cnt_q   <= 3'd0;
              miso_q  <= 1'b0;
              oe_q    <= 1'b1;
            end else if (!cs_s) begin
              state_q <= WAIT_CS;
            end
          end
          WAIT_CS: begin
            if (cs_s) state_q <= IDLE;
          end
          CMD: begin
            if (sclk_rise) begin
              shift_q <= byte_d[6:0];
              cnt_q   <= cnt_q + 3'd1;
              if (byte_done_d) begin
                rw_q    <= byte_d[7];
                mb_q    <= byte_d[6];
                addr_q  <= byte_d[5:0];
                tx_q    <= byte_d[7] ? fetch_d : 8'd0;
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_q <= byte_d[6:0];
              cnt_q   <= cnt_q + 3'd1;
              if (byte_done_d) begin
                addr_q <= addr_nxt_d;
                tx_q   <= rw_q ? fetch_d : 8'd0;
              end
            end else if (sclk_fall && rw_q) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign SPI_MISO  = miso_q;
  assign miso_oe   = oe_q & ~cs_rise;
  assign busy      = (state_q == CMD) || (state_q == DATA);
  assign loc_rdata = (loc_addr == 6'd0) ? DEVID : mem_q[loc_addr];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: mode-3 SPI master driver, register-bank model, strobe scoreboard.
module tb_spi_slave_regfile;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n, SPI_CLK, SPI_CS, SPI_MOSI, SPI_MISO, miso_oe, busy;
  logic       loc_we, wr_strobe;
  logic [5:0] loc_addr, wr_addr;
  logic [7:0] loc_wdata, loc_rdata, wr_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_rise_cyc = 0;
  int          strobe_cyc = 0;
  int          coll_dly = 2;
  logic [7:0]  model [64];
  logic [7:0]  dbuf [8];
  logic [13:0] obs_q[$];
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_regfile #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .miso_oe(miso_oe), .busy(busy), .loc_we(loc_we),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      strobe_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = (i == 0) ? 8'hE5 : 8'h00;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPI_CLK  = 1'b0;
      SPI_MOSI = tx[i];
      wait_clk(HALF);
      rx[i]    = SPI_MISO;
      SPI_CLK  = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(HALF);
    end
  endtask

  task automatic cs_low();
    SPI_CS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    SPI_CS = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic loc_w(input logic [5:0] a, input logic [7:0] d);
    loc_addr  = a;
    loc_wdata = d;
    loc_we    = 1'b1;
    wait_clk(1);
    loc_we    = 1'b0;
    if (a != 6'd0) model[a] = d;
  endtask

  task automatic loc_chk(input string tag, input logic [5:0] a);
    loc_addr = a;
    #1;
    check(tag, loc_rdata, model[a]);
  endtask

  // One whole frame; expected read bytes and write strobes come from the model.
  task automatic frame(input string tag, input logic [7:0] cmd, input int n);
    logic [5:0] a;
    logic [7:0] rx;
    a = cmd[5:0];
    obs_q.delete();
    exp_q.delete();
    cs_low();
    check({tag, "_oe"}, miso_oe, 1);
    spi_xfer(cmd, 8, rx);
    check({tag, "_cmd_miso"}, rx, 0);
    for (int k = 0; k < n; k++) begin
      spi_xfer(dbuf[k], 8, rx);
      if (cmd[7]) begin
        check($sformatf("%s_rd%0d", tag, k), rx, model[a]);
      end else begin
        check($sformatf("%s_wmiso%0d", tag, k), rx, 0);
        if (a != 6'd0) begin
          model[a] = dbuf[k];
          exp_q.push_back({a, dbuf[k]});
        end
      end
      if (cmd[6]) a = a + 6'd1;
    end
    cs_high();
    check({tag, "_oe_off"}, miso_oe, 0);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_nstrobe"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check($sformatf("%s_strobe%0d", tag, k), obs_q[k], exp_q[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    rst_n = 1'b0; SPI_CLK = 1'b1; SPI_CS = 1'b1; SPI_MOSI = 1'b0;
    loc_we = 1'b0; loc_addr = 6'd0; loc_wdata = 8'd0;
    model_reset();
    wait_clk(4);
    check("rst_miso", SPI_MISO, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    wait_clk(8);
    loc_chk("rst_reg00", 6'h00);
    loc_chk("rst_reg15", 6'h15);

    dbuf[0] = 8'h00;
    frame("rd_devid", 8'h80, 1);

    dbuf[0] = 8'h08;
    frame("wr_2d", 8'h2D, 1);
    coll_dly = strobe_cyc - 1 - last_rise_cyc;
    if (coll_dly < 0) coll_dly = 0;
    frame("rd_2d", 8'hAD, 1);
    loc_chk("loc_2d", 6'h2D);

    for (int i = 0; i < 6; i++) loc_w(6'h32 + 6'(i), 8'h11 * 8'(i + 1));
    frame("rd_burst", 8'hF2, 6);

    dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
    frame("mb_wrap", 8'h7F, 2);
    loc_chk("wrap_3f", 6'h3F);
    loc_chk("wrap_00", 6'h00);

    dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h03;
    frame("fixed_addr", 8'h3E, 3);
    loc_chk("fixed_3e", 6'h3E);

    obs_q.delete();
    cs_low();
    spi_xfer(8'h31, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    cs_high();
    check("part_busy", busy, 0);
    check("part_nstrobe", obs_q.size(), 0);
    loc_chk("part_31", 6'h31);

    dbuf[0] = 8'h5A;
    fork
      frame("collide", 8'h20, 1);
      begin
        repeat (16) @(posedge SPI_CLK);
        repeat (coll_dly) @(negedge clk);
        loc_addr = 6'h20; loc_wdata = 8'hC3; loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
      end
    join
    loc_chk("collide_20", 6'h20);

    loc_w(6'h10, 8'h77);
    obs_q.delete();
    cs_low();
    spi_xfer(8'h10, 8, rx);
    spi_xfer(8'hA5, 3, rx);
    rst_n = 1'b0;
    wait_clk(3);
    check("mrst_miso", SPI_MISO, 0);
    check("mrst_oe", miso_oe, 0);
    rst_n = 1'b1;
    model_reset();
    wait_clk(4);
    spi_xfer(8'h15, 5, rx);
    spi_xfer(8'h99, 8, rx);
    check("mrst_oe_rest", miso_oe, 0);
    cs_high();
    check("mrst_nstrobe", obs_q.size(), 0);
    loc_chk("mrst_10", 6'h10);
    loc_chk("mrst_2d", 6'h2D);
    dbuf[0] = 8'h00;
    frame("mrst_rd10", 8'h90, 1);

    for (int it = 0; it < 24; it++) begin
      int n;
      loc_w(6'($urandom_range(0, 63)), 8'($urandom));
      loc_w(6'($urandom_range(0, 63)), 8'($urandom));
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) dbuf[k] = 8'($urandom);
      frame($sformatf("rnd%0d", it), 8'($urandom), n);
      loc_chk($sformatf("rnd%0d_loc", it), 6'($urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
